cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus (CDB) between N_REQ result producers (ALU, forwarder, load unit, ...).
//  Each producer pushes (tag, value) results into its own DEPTH-entry FIFO.
//  A round-robin scheduler pops at most one result per cycle and broadcasts it, registered, on cdb_target/cdb_result.
//  The ROB and the reservation stations snoop these outputs.
// PARAMETERS
//  N_REQ        4      number of requesters
//  TAG_W        5      instruction tag width
//  VAL_W        32     result width
//  DEPTH        2      per-requester FIFO entries (power of 2, >=1)
//  TAG_INVALID  5'h1F  "no tag" encoding; width TAG_W
// PORTS
//  clk          in   1              clock; all state updates on posedge
//  rst          in   1              synchronous reset, active-high
//  flush        in   1              squash all buffered results (mispredict)
//  stall        in   1              CDB unavailable this cycle; no grant
//  req_valid    in   N_REQ          requester i offers a result
//  req_ready    out  N_REQ          FIFO i can accept
//  req_tag      in   N_REQ*TAG_W    slice i = tag of requester i
//  req_val      in   N_REQ*VAL_W    slice i = value of requester i
//  cdb_target   out  TAG_W          broadcast tag; TAG_INVALID = idle
//  cdb_result   out  VAL_W          broadcast value
//  cdb_src      out  $clog2(N_REQ)  index of the winning requester
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - All FIFOs are emptied and rr_ptr is set to 0.
//   - Outputs: cdb_target=TAG_INVALID, cdb_result=0, cdb_src=0.
//   - req_ready=0 while rst is high (combinational on rst).
//  Priority: rst > flush > stall > normal operation.
//  req_ready[i] = !rst && count[i]<DEPTH.
//   - It is derived from the count before the edge.
//   - A full FIFO that is being popped this cycle still shows ready=0 (no pass-through).
//  Push:
//   - req_valid[i] && req_ready[i] at posedge enqueues slice i.
//   - If the tag equals TAG_INVALID, the handshake completes but the entry is discarded.
//  Arbitration each posedge when !stall and !flush:
//   - The winner is the first non-empty FIFO scanning i = rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - The winner's head is popped.
//   - cdb_target, cdb_result and cdb_src are loaded with the head's tag, value and the winner index.
//   - rr_ptr <= (winner+1) mod N_REQ.
//   - The arbiter looks only at FIFO contents from before the edge. An entry pushed at edge k is
//     broadcast at edge k+1 at the earliest, so there is no same-cycle bypass.
//  No candidate:
//   - cdb_target <= TAG_INVALID; cdb_result and cdb_src hold; rr_ptr holds.
//  Single-cycle pulse: each accepted entry appears on the CDB for exactly one cycle, exactly once.
//  Ordering: entries from one requester are broadcast in push order.
//   - No ordering is guaranteed across requesters.
//  stall=1:
//   - No pop; cdb_target <= TAG_INVALID; rr_ptr holds.
//   - Pushes still occur.
//  flush=1:
//   - All FIFOs are emptied and cdb_target <= TAG_INVALID.
//   - Pushes in the same cycle are dropped (their handshake still completes).
//   - rr_ptr holds.
//  Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
//  FIFO pointers wrap mod DEPTH. count is $clog2(DEPTH)+1 bits wide and never exceeds DEPTH.
//  Fairness: with all N_REQ FIFOs continuously non-empty, each requester is granted once every N_REQ cycles.
// TESTING
//  1. Reset: hold rst 2 cycles with req_valid=4'hF.
//     -> req_ready=0, cdb_target=5'h1F, cdb_result=0; after release, no broadcast occurs.
//  2. Single push: req 2 pushes tag 3, val 32'hDEAD_BEEF at edge k.
//     -> cdb_target=3, cdb_result=DEADBEEF, cdb_src=2 for the one cycle after edge k+1, then 5'h1F.
//  3. Round robin: all 4 requesters each push 2 entries (tags 0..7) in one burst.
//     -> broadcast order by src is 0,1,2,3,0,1,2,3; each requester's tags come out in push order.
//  4. Backpressure: req 1 pushes 3 results back-to-back under stall=1.
//     -> ready drops after 2; the third is held and accepted only after stall is released and a pop frees space.
//  5. Flush: fill FIFOs 0 and 3, then assert flush for one cycle together with a push on req 1.
//     -> cdb_target=5'h1F for all following cycles; no flushed or same-cycle tag ever appears.
//  6. Invalid tag: push tag 5'h1F on req 0.
//     -> handshake completes, nothing is broadcast, and req_ready[0] stays 1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the single common data bus (CDB) between N_REQ result producers.
// Each producer pushes (tag, value) results into its own DEPTH-entry FIFO.
// A round-robin scheduler pops at most one FIFO head per cycle and drives it,
// registered, onto the CDB. The ROB and the reservation stations snoop the
// CDB outputs.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous reset, active-high
//   i_flush        squash every buffered result (mispredict recovery)
//   i_stall        CDB unavailable this cycle, so no grant is made
//   i_req_valid    per-requester "result offered"
//   o_req_ready    per-requester "FIFO can accept"
//   i_req_tag      packed tags, slice i belongs to requester i
//   i_req_val      packed values, slice i belongs to requester i
//   o_cdb_target   broadcast tag, TAG_INVALID when the bus is idle
//   o_cdb_result   broadcast value, holds while the bus is idle
//   o_cdb_src      index of the requester that won the last broadcast
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int                N_REQ       = 4,
    parameter int                TAG_W       = 5,
    parameter int                VAL_W       = 32,
    parameter int                DEPTH       = 2,
    parameter logic [TAG_W-1:0]  TAG_INVALID = {TAG_W{1'b1}}
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic                          i_stall,
    input  logic [N_REQ-1:0]              i_req_valid,
    output logic [N_REQ-1:0]              o_req_ready,
    input  logic [N_REQ*TAG_W-1:0]        i_req_tag,
    input  logic [N_REQ*VAL_W-1:0]        i_req_val,
    output logic [TAG_W-1:0]              o_cdb_target,
    output logic [VAL_W-1:0]              o_cdb_result,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] o_cdb_src
);

    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [TAG_W-1:0] r_tag_mem [N_REQ][DEPTH];
    logic [VAL_W-1:0] r_val_mem [N_REQ][DEPTH];
    logic [PTR_W-1:0] r_wr_ptr  [N_REQ];
    logic [PTR_W-1:0] r_rd_ptr  [N_REQ];
    logic [CNT_W-1:0] r_count   [N_REQ];

    logic [SRC_W-1:0] r_rr_ptr;
    logic [TAG_W-1:0] r_cdb_target;
    logic [VAL_W-1:0] r_cdb_result;
    logic [SRC_W-1:0] r_cdb_src;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic [N_REQ-1:0] w_ready;
    logic [N_REQ-1:0] w_nonempty;
    logic [N_REQ-1:0] w_push;
    logic [N_REQ-1:0] w_pop;
    logic             w_found;
    logic             w_grant;
    logic [SRC_W-1:0] w_winner;
    logic [SRC_W-1:0] w_next_rr;
    logic [TAG_W-1:0] w_head_tag;
    logic [VAL_W-1:0] w_head_val;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Ready comes from the count before the edge, so a full FIFO that is
    // being popped this cycle still refuses the new entry (no pass-through).
    // An invalid tag still handshakes but is never written; a flush drops
    // any push of the same cycle while still completing its handshake.
    always_comb begin
        w_ready    = '0;
        w_nonempty = '0;
        w_push     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_ready[i]    = !i_rst && (r_count[i] < CNT_W'(DEPTH));
            w_nonempty[i] = (r_count[i] != '0);
            w_push[i]     = i_req_valid[i] && w_ready[i] && !i_flush &&
                            (i_req_tag[i*TAG_W +: TAG_W] != TAG_INVALID);
        end
    end

    // Round-robin scan starting at r_rr_ptr. Only pre-edge FIFO contents are
    // considered, so an entry pushed at edge k can win at edge k+1 earliest.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_found && w_nonempty[idx]) begin
                w_found  = 1'b1;
                w_winner = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        w_grant = w_found && !i_stall && !i_flush && !i_rst;
        w_pop   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pop[i] = w_grant && (w_winner == SRC_W'(i));
        end
        w_next_rr = (w_winner == SRC_W'(N_REQ - 1)) ? '0
                                                     : SRC_W'(w_winner + SRC_W'(1));
        w_head_tag = r_tag_mem[w_winner][r_rd_ptr[w_winner]];
        w_head_val = r_val_mem[w_winner][r_rd_ptr[w_winner]];
    end

    // -----------------------------------------------------------------------
    // FIFO data path: no reset needed, the count qualifies every entry.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (w_push[i]) begin
                r_tag_mem[i][r_wr_ptr[i]] <= i_req_tag[i*TAG_W +: TAG_W];
                r_val_mem[i][r_wr_ptr[i]] <= i_req_val[i*VAL_W +: VAL_W];
            end
        end
    end

    // FIFO pointers and occupancy. Reset and flush both empty every FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= f_ptr_inc(r_wr_ptr[i]);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= f_ptr_inc(r_rd_ptr[i]);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Broadcast register and round-robin pointer.
    // Priority: reset, then flush, then stall, then normal arbitration.
    // Result and source hold while idle; only the tag signals "no broadcast".
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cdb_target <= TAG_INVALID;
            r_cdb_result <= '0;
            r_cdb_src    <= '0;
            r_rr_ptr     <= '0;
        end else if (i_flush || i_stall) begin
            r_cdb_target <= TAG_INVALID;
        end else if (w_found) begin
            r_cdb_target <= w_head_tag;
            r_cdb_result <= w_head_val;
            r_cdb_src    <= w_winner;
            r_rr_ptr     <= w_next_rr;
        end else begin
            r_cdb_target <= TAG_INVALID;
        end
    end

    assign o_req_ready  = w_ready;
    assign o_cdb_target = r_cdb_target;
    assign o_cdb_result = r_cdb_result;
    assign o_cdb_src    = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Drives cdb_arbiter with directed scenarios followed by random traffic and
// compares every cycle against a queue-based reference model of the bus.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int          N    = 4;
    localparam int          TW   = 5;
    localparam int          VW   = 32;
    localparam int          D    = 2;
    localparam logic [4:0]  TINV = 5'h1F;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_flush;
    logic           i_stall;
    logic [N-1:0]   i_req_valid;
    logic [N-1:0]   o_req_ready;
    logic [N*TW-1:0] i_req_tag;
    logic [N*VW-1:0] i_req_val;
    logic [TW-1:0]  o_cdb_target;
    logic [VW-1:0]  o_cdb_result;
    logic [1:0]     o_cdb_src;

    always #5 i_clk = ~i_clk;

    cdb_arbiter #(
        .N_REQ      (N),
        .TAG_W      (TW),
        .VAL_W      (VW),
        .DEPTH      (D),
        .TAG_INVALID(TINV)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_flush),
        .i_stall     (i_stall),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_tag   (i_req_tag),
        .i_req_val   (i_req_val),
        .o_cdb_target(o_cdb_target),
        .o_cdb_result(o_cdb_result),
        .o_cdb_src   (o_cdb_src)
    );

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] val;
    } ent_t;

    // Reference model: one queue per requester plus the visible bus state.
    ent_t        q [N][$];
    int          m_rr;
    logic [4:0]  m_tgt;
    logic [31:0] m_res;
    logic [1:0]  m_src;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance the model across the
    // edge, then check the registered bus outputs.
    task automatic cycle(input logic rst, input logic flush, input logic stall,
                         input logic [N-1:0] v, input logic [N*TW-1:0] tags,
                         input logic [N*VW-1:0] vals);
        logic [N-1:0] exp_rdy;
        int           win;
        int           idx;
        ent_t         e;
        i_rst       = rst;
        i_flush     = flush;
        i_stall     = stall;
        i_req_valid = v;
        i_req_tag   = tags;
        i_req_val   = vals;
        #1;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = !rst && (q[i].size() < D);
        end
        chk("req_ready", 32'(o_req_ready), 32'(exp_rdy));

        if (rst) begin
            for (int i = 0; i < N; i++) q[i].delete();
            m_rr  = 0;
            m_tgt = TINV;
            m_res = '0;
            m_src = '0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
            m_tgt = TINV;
        end else begin
            if (stall) begin
                m_tgt = TINV;
            end else begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (win < 0 && q[idx].size() > 0) win = idx;
                end
                if (win < 0) begin
                    m_tgt = TINV;
                end else begin
                    e     = q[win].pop_front();
                    m_tgt = e.tag;
                    m_res = e.val;
                    m_src = 2'(win);
                    m_rr  = (win + 1) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_rdy[i] && tags[i*TW +: TW] != TINV) begin
                    e.tag = tags[i*TW +: TW];
                    e.val = vals[i*VW +: VW];
                    q[i].push_back(e);
                end
            end
        end

        @(posedge i_clk);
        #2;
        chk("cdb_target", 32'(o_cdb_target), 32'(m_tgt));
        chk("cdb_result", o_cdb_result, m_res);
        chk("cdb_src", 32'(o_cdb_src), 32'(m_src));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    logic [N*TW-1:0] rt;
    logic [N*VW-1:0] rv;
    logic [N-1:0]    rvld;
    logic            r_st;
    logic            r_fl;
    logic            r_rs;

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_stall = 1'b0;
        i_req_valid = '0; i_req_tag = '0; i_req_val = '0;
        @(posedge i_clk);
        #2;

        // Reset held two cycles with every requester offering.
        cycle(1'b1, 1'b0, 1'b0, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {4{32'h1234_5678}});
        cycle(1'b1, 1'b0, 1'b0, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {4{32'h1234_5678}});
        chk("t1_ready", 32'(o_req_ready), 32'h0);
        chk("t1_target", 32'(o_cdb_target), 32'h1F);
        chk("t1_result", o_cdb_result, 32'h0);
        idle(2);
        chk("t1_no_bcast", 32'(o_cdb_target), 32'h1F);

        // Single push on requester 2.
        cycle(1'b0, 1'b0, 1'b0, 4'b0100, {5'd0, 5'd3, 5'd0, 5'd0},
              {32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0});
        chk("t2_not_yet", 32'(o_cdb_target), 32'h1F);
        idle(1);
        chk("t2_target", 32'(o_cdb_target), 32'd3);
        chk("t2_result", o_cdb_result, 32'hDEAD_BEEF);
        chk("t2_src", 32'(o_cdb_src), 32'd2);
        idle(1);
        chk("t2_pulse_end", 32'(o_cdb_target), 32'h1F);

        // Round robin: reset the pointer, then a two-deep burst on all four.
        cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
        cycle(1'b0, 1'b0, 1'b0, 4'hF, {5'd3, 5'd2, 5'd1, 5'd0},
              {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        cycle(1'b0, 1'b0, 1'b0, 4'hF, {5'd7, 5'd6, 5'd5, 5'd4},
              {32'hA7, 32'hA6, 32'hA5, 32'hA4});
        chk("t3_tag0", 32'(o_cdb_target), 32'd0);
        chk("t3_src0", 32'(o_cdb_src), 32'd0);
        for (int k = 1; k < 8; k++) begin
            idle(1);
            chk("t3_tag", 32'(o_cdb_target), 32'(k));
            chk("t3_src", 32'(o_cdb_src), 32'(k % 4));
        end
        idle(1);
        chk("t3_drained", 32'(o_cdb_target), 32'h1F);

        // Backpressure on requester 1 while stalled.
        cycle(1'b0, 1'b0, 1'b1, 4'b0010, {5'd0, 5'd0, 5'd8, 5'd0}, {32'd0, 32'd0, 32'h80, 32'd0});
        cycle(1'b0, 1'b0, 1'b1, 4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, {32'd0, 32'd0, 32'h90, 32'd0});
        chk("t4_full", 32'(o_req_ready[1]), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 4'b0010, {5'd0, 5'd0, 5'd10, 5'd0}, {32'd0, 32'd0, 32'hA0, 32'd0});
        cycle(1'b0, 1'b0, 1'b0, 4'b0010, {5'd0, 5'd0, 5'd10, 5'd0}, {32'd0, 32'd0, 32'hA0, 32'd0});
        chk("t4_pop8", 32'(o_cdb_target), 32'd8);
        cycle(1'b0, 1'b0, 1'b0, 4'b0010, {5'd0, 5'd0, 5'd10, 5'd0}, {32'd0, 32'd0, 32'hA0, 32'd0});
        idle(1);
        chk("t4_tag10", 32'(o_cdb_target), 32'd10);
        idle(1);

        // Flush with a same-cycle push on requester 1.
        cycle(1'b0, 1'b0, 1'b1, 4'b1001, {5'd13, 5'd0, 5'd0, 5'd11}, {32'hD, 32'd0, 32'd0, 32'hB});
        cycle(1'b0, 1'b0, 1'b1, 4'b1001, {5'd14, 5'd0, 5'd0, 5'd12}, {32'hE, 32'd0, 32'd0, 32'hC});
        cycle(1'b0, 1'b1, 1'b0, 4'b0010, {5'd0, 5'd0, 5'd15, 5'd0}, {32'd0, 32'd0, 32'hF, 32'd0});
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("t5_flushed", 32'(o_cdb_target), 32'h1F);
        end

        // Invalid tag is accepted but never stored.
        cycle(1'b0, 1'b0, 1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'h1F}, {32'd0, 32'd0, 32'd0, 32'h77});
        #1;
        chk("t6_ready", 32'(o_req_ready[0]), 32'd1);
        idle(2);
        chk("t6_no_bcast", 32'(o_cdb_target), 32'h1F);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                rt[i*TW +: TW] = 5'($urandom_range(0, 31));
                rv[i*VW +: VW] = $urandom;
            end
            rvld = 4'($urandom);
            r_st = ($urandom_range(0, 99) < 20);
            r_fl = ($urandom_range(0, 99) < 3);
            r_rs = ($urandom_range(0, 99) < 1);
            cycle(r_rs, r_fl, r_st, rvld, rt, rv);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
